pipeline_skid_register: RTL

PIPELINE_SKID_REGISTER -- requirements
Module: pipeline_skid_register

---
 rtl/pipeline_skid_register_pkg.sv | 19 +
 rtl/pipeline_data_reg.sv | 20 ++
 rtl/pipeline_skid_register.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipeline_skid_register_pkg.sv
// Shared types and constants for the pipeline skid register.
package pipeline_skid_register_pkg;

   localparam int unsigned DEFAULT_NR_OF_BITS = 32;
   localparam int unsigned OCC_W              = 2;

   // State encoding doubles as the entry count.
   typedef enum logic [OCC_W-1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Entry count presented on the occupancy port.
   function automatic logic [OCC_W-1:0] occ_of(input state_t s);
      return OCC_W'(s);
   endfunction

endpackage

// File: rtl/pipeline_data_reg.sv
// Data entry register with synchronous load enable.
module pipeline_data_reg
   import pipeline_skid_register_pkg::*;
#(
   parameter int unsigned NrOfBits = DEFAULT_NR_OF_BITS
) (
   input  logic                clock,
   input  logic                load,
   input  logic [NrOfBits-1:0] value,
   output logic [NrOfBits-1:0] q
);

   // Capture value whenever load is asserted, otherwise hold.
   always_ff @(posedge clock) begin
      if (load) begin
         q <= value;
      end
   end

endmodule

// File: rtl/pipeline_skid_register.sv
// Two-entry skid register: full-throughput handshake with a registered in_ready.
module pipeline_skid_register
   import pipeline_skid_register_pkg::*;
#(
   parameter int unsigned          NrOfBits    = DEFAULT_NR_OF_BITS,
   parameter logic [NrOfBits-1:0]  ResetValue  = '0,
   parameter logic [NrOfBits-1:0]  PresetValue = '1
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                ClockEnable,
   input  logic                Tick,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NrOfBits-1:0] D,
   input  logic                flush,
   input  logic                pre,
   input  logic                cs,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NrOfBits-1:0] Q,
   output logic [OCC_W-1:0]    occupancy
);

   state_t              state;
   state_t              state_next;
   logic                adv;
   logic                in_fire;
   logic                out_fire;
   logic                out_load;
   logic                skid_load;
   logic [NrOfBits-1:0] out_value;
   logic [NrOfBits-1:0] skid_value;
   logic [NrOfBits-1:0] out_q;
   logic [NrOfBits-1:0] skid_q;

   assign adv      = ClockEnable & Tick;
   assign in_fire  = in_valid & in_ready & adv;
   assign out_fire = out_valid & out_ready & adv;

   // Next state and entry load controls; Reset > flush > pre > handshake.
   always_comb begin
      state_next = state;
      out_load   = 1'b0;
      out_value  = D;
      skid_load  = 1'b0;
      skid_value = D;
      if (Reset || flush) begin
         state_next = ST_EMPTY;
         out_load   = 1'b1;
         out_value  = ResetValue;
         skid_load  = 1'b1;
         skid_value = ResetValue;
      end else if (pre) begin
         state_next = ST_ONE;
         out_load   = 1'b1;
         out_value  = PresetValue;
         skid_load  = 1'b1;
         skid_value = ResetValue;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  out_load   = 1'b1;
                  state_next = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  out_load = 1'b1;
               end else if (in_fire) begin
                  skid_load  = 1'b1;
                  state_next = ST_FULL;
               end else if (out_fire) begin
                  state_next = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  out_load   = 1'b1;
                  out_value  = skid_q;
                  state_next = ST_ONE;
               end
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   // State register with registered handshake and occupancy outputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         occupancy <= occ_of(ST_EMPTY);
      end else begin
         state     <= state_next;
         in_ready  <= (state_next != ST_FULL);
         out_valid <= (state_next != ST_EMPTY);
         occupancy <= occ_of(state_next);
      end
   end

   pipeline_data_reg #(.NrOfBits(NrOfBits)) u_out_entry (
      .clock (Clock),
      .load  (out_load),
      .value (out_value),
      .q     (out_q)
   );

   pipeline_data_reg #(.NrOfBits(NrOfBits)) u_skid_entry (
      .clock (Clock),
      .load  (skid_load),
      .value (skid_value),
      .q     (skid_q)
   );

   // Output entry is released to high impedance while cs is high.
   assign Q = cs ? 'z : out_q;

endmodule
